// File: rtl/sobel_grad_pipe.sv
// Streaming 3x3 Sobel gradient engine: one pixel column per beat, signed gx/gy per window centre.
// Define SOBEL_AMP_EN to add a third stage producing out_amp = |gx| + |gy|.
module sobel_grad_pipe #(
  parameter int PIX_W = 8,
  parameter int BLK_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sor,
  input  logic [PIX_W-1:0]        in_top,
  input  logic [PIX_W-1:0]        in_mid,
  input  logic [PIX_W-1:0]        in_bot,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_eor,
  output logic signed [PIX_W+2:0] out_gx,
  output logic signed [PIX_W+2:0] out_gy
`ifdef SOBEL_AMP_EN
  ,
  output logic [PIX_W+2:0]        out_amp
`endif
);

  localparam int GW = PIX_W + 3;
  localparam int SW = PIX_W + 2;
  localparam int CW = (BLK_W <= 2) ? 1 : $clog2(BLK_W);

  logic          adv, acc, issue, is_last;
  logic [CW-1:0] col_cnt, idx;

  logic [PIX_W-1:0] wl_t, wl_m, wl_b;
  logic [PIX_W-1:0] wc_t, wc_m, wc_b;

  logic [SW-1:0] s1_l, s1_r, s1_t, s1_b;
  logic          s1_v, s1_eor;

  logic signed [GW-1:0] s2_gx, s2_gy;
  logic                 s2_v, s2_eor;

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  // in_sor forces index 0, discarding whatever partial window was in flight
  always_comb begin
    idx     = in_sor ? '0 : col_cnt;
    issue   = acc && (idx >= CW'(2));
    is_last = (idx == CW'(BLK_W - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_cnt <= '0;
    end else if (clr) begin
      col_cnt <= '0;
    end else if (acc) begin
      col_cnt <= is_last ? '0 : idx + CW'(1);
    end
  end

  // Window holds the two previous columns; the incoming column is the right edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wl_t <= '0; wl_m <= '0; wl_b <= '0;
      wc_t <= '0; wc_m <= '0; wc_b <= '0;
    end else if (acc && !clr) begin
      wl_t <= wc_t;   wl_m <= wc_m;   wl_b <= wc_b;
      wc_t <= in_top; wc_m <= in_mid; wc_b <= in_bot;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v   <= 1'b0;
      s1_eor <= 1'b0;
      s1_l   <= '0;
      s1_r   <= '0;
      s1_t   <= '0;
      s1_b   <= '0;
    end else if (clr) begin
      s1_v   <= 1'b0;
      s1_eor <= 1'b0;
    end else if (adv) begin
      s1_v   <= issue;
      s1_eor <= issue & is_last;
      if (issue) begin
        s1_l <= wsum(wl_t, wl_m, wl_b);
        s1_r <= wsum(in_top, in_mid, in_bot);
        s1_t <= wsum(wl_t, wc_t, in_top);
        s1_b <= wsum(wl_b, wc_b, in_bot);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v   <= 1'b0;
      s2_eor <= 1'b0;
      s2_gx  <= '0;
      s2_gy  <= '0;
    end else if (clr) begin
      s2_v   <= 1'b0;
      s2_eor <= 1'b0;
      s2_gx  <= '0;
      s2_gy  <= '0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_eor <= s1_eor;
      if (s1_v) begin
        s2_gx <= $signed({1'b0, s1_l}) - $signed({1'b0, s1_r});
        s2_gy <= $signed({1'b0, s1_t}) - $signed({1'b0, s1_b});
      end
    end
  end

`ifdef SOBEL_AMP_EN
  logic signed [GW-1:0] s3_gx, s3_gy;
  logic [GW-1:0]        s3_amp;
  logic                 s3_v, s3_eor;

  // Magnitude never exceeds 4*(2^PIX_W-1), so negation cannot overflow
  function automatic logic [GW-1:0] mag(input logic signed [GW-1:0] x);
    return x[GW-1] ? GW'(-x) : GW'(x);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_v   <= 1'b0;
      s3_eor <= 1'b0;
      s3_gx  <= '0;
      s3_gy  <= '0;
      s3_amp <= '0;
    end else if (clr) begin
      s3_v   <= 1'b0;
      s3_eor <= 1'b0;
      s3_gx  <= '0;
      s3_gy  <= '0;
      s3_amp <= '0;
    end else if (adv) begin
      s3_v   <= s2_v;
      s3_eor <= s2_eor;
      if (s2_v) begin
        s3_gx  <= s2_gx;
        s3_gy  <= s2_gy;
        s3_amp <= mag(s2_gx) + mag(s2_gy);
      end
    end
  end

  assign out_valid = s3_v;
  assign out_eor   = s3_eor;
  assign out_gx    = s3_gx;
  assign out_gy    = s3_gy;
  assign out_amp   = s3_amp;
`else
  assign out_valid = s2_v;
  assign out_eor   = s2_eor;
  assign out_gx    = s2_gx;
  assign out_gy    = s2_gy;
`endif

endmodule
